// File: rtl/atm_pkg.sv
// atm_pkg -- shared definitions for the ATM keypad entry block.
//   Key codes produced by the keypad scanner, the entry-state encoding
//   visible on entry_state, and the largest amount that can be delivered.
package atm_pkg;

  // Keypad codes 0-9 are digits; A-D are command keys; E/F never valid.
  localparam logic [3:0] KEY_DIGIT_MAX = 4'h9;
  localparam logic [3:0] KEY_CLEAR     = 4'hA;
  localparam logic [3:0] KEY_BACK      = 4'hB;
  localparam logic [3:0] KEY_ENTER     = 4'hC;
  localparam logic [3:0] KEY_CANCEL    = 4'hD;

  // Largest amount representable on the 16-bit amount output.
  localparam logic [15:0] AMOUNT_LIMIT = 16'd65535;

  typedef enum logic [1:0] {
    ENTRY_IDLE = 2'd0,
    ENTRY_PIN  = 2'd1,
    ENTRY_AMT  = 2'd2
  } entry_state_e;

  function automatic logic is_digit(input logic [3:0] code);
    return code <= KEY_DIGIT_MAX;
  endfunction

endpackage

// File: rtl/atm_dec_accum.sv
// atm_dec_accum -- decimal accumulator for amount entry.
//   clk    : clock, rising edge
//   rst    : synchronous active-high reset, clears the accumulator
//   clr    : clear accumulator to 0
//   push   : append digit (acc*10+digit) unless that would overflow
//   pop    : drop last digit (acc/10)
//   digit  : decimal digit 0-9 to append
//   acc    : current accumulated value
//   ovf    : appending digit now would exceed AMOUNT_LIMIT
// clr wins over push, push over pop; the caller never asserts more than one.
module atm_dec_accum
  import atm_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        push,
  input  logic        pop,
  input  logic [3:0]  digit,
  output logic [15:0] acc,
  output logic        ovf
);

  // 65535*10+9 fits in 20 bits, so the candidate never wraps.
  logic [19:0] pushed;

  assign pushed = ({4'h0, acc} * 20'd10) + {16'h0, digit};
  assign ovf    = pushed > {4'h0, AMOUNT_LIMIT};

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      acc <= '0;
    end else if (push && !ovf) begin
      acc <= pushed[15:0];
    end else if (pop) begin
      acc <= acc / 16'd10;
    end
  end

endmodule

// File: rtl/atm_keypad_entry.sv
// atm_keypad_entry -- PIN / amount entry controller for an ATM keypad.
//   clk          : clock, rising edge
//   rst          : synchronous active-high reset
//   pin_req      : pulse, open PIN entry (wins when both requests arrive)
//   amount_req   : pulse, open amount entry
//   key_valid    : strobe, key_code valid this cycle
//   key_code     : 0-9 digit, A clear, B backspace, C enter, D cancel
//   pin_input    : last delivered PIN, 4 packed BCD digits, first in [15:12]
//   pin_valid    : pulse, pin_input updated
//   amount       : last delivered amount, unsigned binary
//   amount_valid : pulse, amount updated
//   digit_count  : digits held in the open entry
//   entry_state  : 0 idle, 1 PIN, 2 amount
//   key_err      : pulse, key rejected
//   cancel       : pulse, entry cancelled by the user
//   timeout      : pulse, entry abandoned by inactivity
// Build option: define ATM_KEYPAD_TIMEOUT_EN to build the inactivity timer;
// otherwise timeout is tied low and TIMEOUT_CYCLES only gets range-checked.
//
// state      | meaning
// -----------+-------------------------------------------------
// ST_IDLE    | no entry open, keys ignored, waiting for a request
// ST_PIN     | collecting up to 4 PIN digits
// ST_AMT     | accumulating a decimal amount up to AMOUNT_LIMIT
module atm_keypad_entry
  import atm_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1000
)
(
  input  logic        clk,
  input  logic        rst,
  input  logic        pin_req,
  input  logic        amount_req,
  input  logic        key_valid,
  input  logic [3:0]  key_code,
  output logic [15:0] pin_input,
  output logic        pin_valid,
  output logic [15:0] amount,
  output logic        amount_valid,
  output logic [2:0]  digit_count,
  output logic [1:0]  entry_state,
  output logic        key_err,
  output logic        cancel,
  output logic        timeout
);

  localparam logic [1:0] ST_IDLE = ENTRY_IDLE;
  localparam logic [1:0] ST_PIN  = ENTRY_PIN;
  localparam logic [1:0] ST_AMT  = ENTRY_AMT;

  localparam logic [2:0] PIN_DIGITS    = 3'd4;
  localparam logic [2:0] AMT_COUNT_MAX = 3'd7;

  if (TIMEOUT_CYCLES == 0) begin : g_bad_timeout
    $error("atm_keypad_entry: TIMEOUT_CYCLES must be at least 1");
  end

  logic [1:0]  state, st_n;
  logic [15:0] pin_buf, buf_n;
  logic [2:0]  cnt_n;
  logic [15:0] pin_input_n, amount_n;
  logic        pin_valid_n, amount_valid_n, key_err_n, cancel_n;
  logic        close_entry, expired;

  logic        acc_clr, acc_push, acc_pop, acc_ovf;
  logic [15:0] acc;

  atm_dec_accum u_accum (
    .clk   (clk),
    .rst   (rst),
    .clr   (acc_clr),
    .push  (acc_push),
    .pop   (acc_pop),
    .digit (key_code),
    .acc   (acc),
    .ovf   (acc_ovf)
  );

  always_comb begin
    st_n           = state;
    buf_n          = pin_buf;
    cnt_n          = digit_count;
    pin_input_n    = pin_input;
    amount_n       = amount;
    pin_valid_n    = 1'b0;
    amount_valid_n = 1'b0;
    key_err_n      = 1'b0;
    cancel_n       = 1'b0;
    close_entry    = 1'b0;
    acc_clr        = 1'b0;
    acc_push       = 1'b0;
    acc_pop        = 1'b0;

    case (state)
      ST_IDLE: begin
        if (pin_req || amount_req) begin
          st_n    = pin_req ? ST_PIN : ST_AMT;
          buf_n   = '0;
          cnt_n   = '0;
          acc_clr = 1'b1;
        end
      end

      ST_PIN: begin
        if (key_valid) begin
          if (is_digit(key_code)) begin
            if (digit_count < PIN_DIGITS) begin
              buf_n = {pin_buf[11:0], key_code};
              cnt_n = digit_count + 3'd1;
            end else begin
              key_err_n = 1'b1;
            end
          end else begin
            case (key_code)
              KEY_CLEAR: begin
                buf_n = '0;
                cnt_n = '0;
              end
              KEY_BACK: begin
                if (digit_count != 3'd0) begin
                  buf_n = {4'h0, pin_buf[15:4]};
                  cnt_n = digit_count - 3'd1;
                end else begin
                  key_err_n = 1'b1;
                end
              end
              KEY_ENTER: begin
                if (digit_count == PIN_DIGITS) begin
                  pin_input_n = pin_buf;
                  pin_valid_n = 1'b1;
                  close_entry = 1'b1;
                end else begin
                  key_err_n = 1'b1;
                end
              end
              KEY_CANCEL: begin
                cancel_n    = 1'b1;
                close_entry = 1'b1;
              end
              default: key_err_n = 1'b1;
            endcase
          end
        end else if (expired) begin
          close_entry = 1'b1;
        end
      end

      ST_AMT: begin
        if (key_valid) begin
          if (is_digit(key_code)) begin
            if (!acc_ovf) begin
              acc_push = 1'b1;
              // Leading zeros still count as keystrokes, hence the clamp.
              cnt_n = (digit_count == AMT_COUNT_MAX) ? AMT_COUNT_MAX
                                                     : digit_count + 3'd1;
            end else begin
              key_err_n = 1'b1;
            end
          end else begin
            case (key_code)
              KEY_CLEAR: begin
                acc_clr = 1'b1;
                cnt_n   = '0;
              end
              KEY_BACK: begin
                if (digit_count != 3'd0) begin
                  acc_pop = 1'b1;
                  cnt_n   = digit_count - 3'd1;
                end else begin
                  key_err_n = 1'b1;
                end
              end
              KEY_ENTER: begin
                if (digit_count != 3'd0) begin
                  amount_n       = acc;
                  amount_valid_n = 1'b1;
                  close_entry    = 1'b1;
                end else begin
                  key_err_n = 1'b1;
                end
              end
              KEY_CANCEL: begin
                cancel_n    = 1'b1;
                close_entry = 1'b1;
              end
              default: key_err_n = 1'b1;
            endcase
          end
        end else if (expired) begin
          close_entry = 1'b1;
        end
      end

      default: st_n = ST_IDLE;
    endcase

    if (close_entry) begin
      st_n    = ST_IDLE;
      buf_n   = '0;
      cnt_n   = '0;
      acc_clr = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      pin_buf      <= '0;
      digit_count  <= '0;
      pin_input    <= '0;
      amount       <= '0;
      pin_valid    <= 1'b0;
      amount_valid <= 1'b0;
      key_err      <= 1'b0;
      cancel       <= 1'b0;
    end else begin
      state        <= st_n;
      pin_buf      <= buf_n;
      digit_count  <= cnt_n;
      pin_input    <= pin_input_n;
      amount       <= amount_n;
      pin_valid    <= pin_valid_n;
      amount_valid <= amount_valid_n;
      key_err      <= key_err_n;
      cancel       <= cancel_n;
    end
  end

  assign entry_state = state;

`ifdef ATM_KEYPAD_TIMEOUT_EN
  localparam int unsigned     TO_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TO_W-1:0] TO_LOAD = TO_W'(TIMEOUT_CYCLES);

  logic [TO_W-1:0] to_cnt;
  logic            timeout_q;

  // Loaded on entry and on every key; a key on the terminal cycle wins.
  assign expired = (state != ST_IDLE) && !key_valid && (to_cnt == TO_W'(1));

  always_ff @(posedge clk) begin
    if (rst) begin
      to_cnt    <= '0;
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= expired;
      if (state == ST_IDLE) begin
        if (pin_req || amount_req) begin
          to_cnt <= TO_LOAD;
        end
      end else if (key_valid) begin
        to_cnt <= TO_LOAD;
      end else if (!expired) begin
        to_cnt <= to_cnt - TO_W'(1);
      end
    end
  end

  assign timeout = timeout_q;
`else
  assign expired = 1'b0;
  assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_atm_keypad_entry.sv
module tb_atm_keypad_entry;

  localparam int TO_CYC = 20;
`ifdef ATM_KEYPAD_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        pin_req = 1'b0;
  logic        amount_req = 1'b0;
  logic        key_valid = 1'b0;
  logic [3:0]  key_code = 4'h0;
  logic [15:0] pin_input;
  logic        pin_valid;
  logic [15:0] amount;
  logic        amount_valid;
  logic [2:0]  digit_count;
  logic [1:0]  entry_state;
  logic        key_err;
  logic        cancel;
  logic        timeout;

  int checks = 0;
  int errors = 0;

  atm_keypad_entry #(.TIMEOUT_CYCLES(TO_CYC)) dut (
    .clk          (clk),
    .rst          (rst),
    .pin_req      (pin_req),
    .amount_req   (amount_req),
    .key_valid    (key_valid),
    .key_code     (key_code),
    .pin_input    (pin_input),
    .pin_valid    (pin_valid),
    .amount       (amount),
    .amount_valid (amount_valid),
    .digit_count  (digit_count),
    .entry_state  (entry_state),
    .key_err      (key_err),
    .cancel       (cancel),
    .timeout      (timeout)
  );

  always #5 clk = ~clk;

  // Reference model: mode 0 idle, 1 PIN, 2 amount; PIN kept as a digit list,
  // amount as a plain integer value plus keystroke count.
  int m_state = 0;
  int m_digits[$];
  int m_val = 0;
  int m_cnt = 0;
  int m_idle = 0;
  int e_pin = 0, e_amt = 0;
  bit e_pv = 0, e_av = 0, e_err = 0, e_can = 0, e_to = 0;

  function automatic int entry_len();
    if (m_state == 1) return m_digits.size();
    if (m_state == 2) return m_cnt;
    return 0;
  endfunction

  function automatic int pin_word();
    int w = 0;
    for (int i = 0; i < 4; i++) w += m_digits[i] * (1 << (4 * (3 - i)));
    return w;
  endfunction

  task automatic close_entry();
    m_state = 0;
    m_digits.delete();
    m_val = 0;
    m_cnt = 0;
  endtask

  task automatic model_clock(input bit r, input bit pr, input bit ar,
                             input bit kv, input int kc);
    int v;
    e_pv = 0; e_av = 0; e_err = 0; e_can = 0; e_to = 0;
    if (r) begin
      close_entry();
      m_idle = 0;
      e_pin = 0;
      e_amt = 0;
    end else if (m_state == 0) begin
      if (pr || ar) begin
        close_entry();
        m_state = pr ? 1 : 2;
        m_idle = 0;
      end
    end else if (kv) begin
      m_idle = 0;
      if (kc <= 9) begin
        if (m_state == 1) begin
          if (m_digits.size() < 4) m_digits.push_back(kc);
          else e_err = 1;
        end else begin
          v = m_val * 10 + kc;
          if (v > 65535) e_err = 1;
          else begin
            m_val = v;
            if (m_cnt < 7) m_cnt++;
          end
        end
      end else if (kc == 10) begin
        m_digits.delete();
        m_val = 0;
        m_cnt = 0;
      end else if (kc == 11) begin
        if (entry_len() == 0) e_err = 1;
        else if (m_state == 1) void'(m_digits.pop_back());
        else begin
          m_val = m_val / 10;
          m_cnt--;
        end
      end else if (kc == 12) begin
        if (m_state == 1 && m_digits.size() == 4) begin
          e_pin = pin_word();
          e_pv = 1;
          close_entry();
        end else if (m_state == 2 && m_cnt > 0) begin
          e_amt = m_val;
          e_av = 1;
          close_entry();
        end else e_err = 1;
      end else if (kc == 13) begin
        e_can = 1;
        close_entry();
      end else e_err = 1;
    end else begin
      m_idle++;
      if (TO_EN && m_idle >= TO_CYC) begin
        e_to = 1;
        close_entry();
      end
    end
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("pin_input", pin_input, 16'(e_pin));
    chk("amount", amount, 16'(e_amt));
    chk("pin_valid", 16'(pin_valid), 16'(e_pv));
    chk("amount_valid", 16'(amount_valid), 16'(e_av));
    chk("digit_count", 16'(digit_count), 16'(entry_len()));
    chk("entry_state", 16'(entry_state), 16'(m_state));
    chk("key_err", 16'(key_err), 16'(e_err));
    chk("cancel", 16'(cancel), 16'(e_can));
    chk("timeout", 16'(timeout), 16'(e_to));
  endtask

  task automatic step(input bit r, input bit pr, input bit ar, input bit kv, input int kc);
    rst = r;
    pin_req = pr;
    amount_req = ar;
    key_valid = kv;
    key_code = 4'(kc);
    @(posedge clk);
    model_clock(r, pr, ar, kv, kc);
    #1;
    check_all();
    rst = 1'b0;
    pin_req = 1'b0;
    amount_req = 1'b0;
    key_valid = 1'b0;
  endtask

  task automatic key(input int kc);
    step(0, 0, 0, 1, kc);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0);
  endtask

  initial begin
    int r2, kc;
    bit pr, ar, kv, rr;

    // Reset state
    step(1, 0, 0, 0, 0);
    chk("reset_state", 16'(entry_state), 16'd0);
    chk("reset_pin", pin_input, 16'h0000);
    idle(2);

    // PIN 1234
    step(0, 1, 0, 0, 0);
    chk("pin_open", 16'(entry_state), 16'd1);
    key(1); key(2); key(3); key(4);
    chk("pin_cnt4", 16'(digit_count), 16'd4);
    key(12);
    chk("pin_1234", pin_input, 16'h1234);
    chk("pin_valid_hi", 16'(pin_valid), 16'd1);
    chk("pin_idle", 16'(entry_state), 16'd0);
    idle(1);
    chk("pin_valid_lo", 16'(pin_valid), 16'd0);

    // Amount 100
    step(0, 0, 1, 0, 0);
    key(1); key(0); key(0); key(12);
    chk("amt_100", amount, 16'h0064);
    chk("amt_valid_hi", 16'(amount_valid), 16'd1);
    idle(1);
    chk("amt_valid_lo", 16'(amount_valid), 16'd0);

    // Amount overflow boundary
    step(0, 0, 1, 0, 0);
    key(6); key(5); key(5); key(3); key(6);
    chk("ovf_err", 16'(key_err), 16'd1);
    chk("ovf_acc", 16'(dut.u_accum.acc), 16'd6553);
    key(5); key(12);
    chk("amt_max", amount, 16'hFFFF);

    // PIN short enter, backspace, then complete
    step(0, 1, 0, 0, 0);
    key(1); key(2); key(12);
    chk("pin_short_err", 16'(key_err), 16'd1);
    chk("pin_short_state", 16'(entry_state), 16'd1);
    key(11);
    chk("pin_back_cnt", 16'(digit_count), 16'd1);
    key(9); key(9); key(9); key(12);
    chk("pin_1999", pin_input, 16'h1999);

    // Cancel keeps delivered PIN; reset mid amount entry
    step(0, 1, 0, 0, 0);
    key(7); key(13);
    chk("cancel_hi", 16'(cancel), 16'd1);
    chk("cancel_pin", pin_input, 16'h1999);
    step(0, 0, 1, 0, 0);
    key(4);
    step(1, 0, 0, 0, 0);
    chk("rst_state", 16'(entry_state), 16'd0);
    chk("rst_pin", pin_input, 16'h0000);
    chk("rst_amt", amount, 16'h0000);
    chk("rst_cnt", 16'(digit_count), 16'd0);

    // Inactivity timeout
`ifdef ATM_KEYPAD_TIMEOUT_EN
    step(0, 1, 0, 0, 0);
    idle(TO_CYC - 1);
    chk("to_early", 16'(timeout), 16'd0);
    idle(1);
    chk("to_fire", 16'(timeout), 16'd1);
    chk("to_idle", 16'(entry_state), 16'd0);
    step(0, 1, 0, 0, 0);
    idle(TO_CYC - 2);
    key(3);
    idle(TO_CYC - 1);
    chk("to_restart", 16'(timeout), 16'd0);
    chk("to_still_pin", 16'(entry_state), 16'd1);
    idle(1);
    chk("to_fire2", 16'(timeout), 16'd1);
`else
    step(0, 1, 0, 0, 0);
    idle(TO_CYC + 5);
    chk("no_to_state", 16'(entry_state), 16'd1);
    key(13);
`endif

    // Randomized traffic against the model
    for (int n = 0; n < 1500; n++) begin
      rr = ($urandom_range(0, 299) == 0);
      pr = ($urandom_range(0, 9) == 0);
      ar = ($urandom_range(0, 9) == 0);
      kv = ($urandom_range(0, 3) != 0);
      r2 = $urandom_range(0, 99);
      if (r2 < 55)      kc = $urandom_range(0, 9);
      else if (r2 < 68) kc = 12;
      else if (r2 < 78) kc = 11;
      else if (r2 < 83) kc = 10;
      else if (r2 < 87) kc = 13;
      else if (r2 < 91) kc = $urandom_range(14, 15);
      else              kc = $urandom_range(6, 9);
      step(rr, pr, ar, kv, kc);
      if ($urandom_range(0, 79) == 0) idle(TO_CYC + 2);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/atm_keypad_entry.md
ATM_KEYPAD_ENTRY -- requirements
Module: atm_keypad_entry

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 1000, idle cycles before an open entry is abandoned.
REQ-002 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port pin_req  input  1  one-cycle pulse; open PIN entry.
REQ-005 SHALL have port amount_req  input  1  one-cycle pulse; open amount entry.
REQ-006 SHALL have port key_valid  input  1  one-cycle strobe; key_code valid this cycle.
REQ-007 SHALL have port key_code  input  4  0-9 digit, A clear, B backspace, C enter, D cancel, E/F invalid.
REQ-008 SHALL have port pin_input  output  16  four packed BCD digits; first digit entered in [15:12].
REQ-009 SHALL have port pin_valid  output  1  one-cycle pulse; pin_input complete.
REQ-010 SHALL have port amount  output  16  unsigned binary amount.
REQ-011 SHALL have port amount_valid  output  1  one-cycle pulse; amount complete.
REQ-012 SHALL have port digit_count  output  3  digits held in the open entry.
REQ-013 SHALL have port entry_state  output  2  0 IDLE, 1 PIN, 2 AMT.
REQ-014 SHALL have port key_err  output  1  one-cycle pulse; key rejected.
REQ-015 SHALL have port cancel  output  1  one-cycle pulse; entry cancelled by user.
REQ-016 SHALL have port timeout  output  1  one-cycle pulse; entry abandoned by inactivity.

Function
REQ-017 All outputs SHALL be registered; a key sampled on cycle N SHALL produce its response on cycle N+1.
REQ-018 IDLE: pin_req moves to PIN, amount_req moves to AMT, both together select PIN; entry clears the digit buffer and digit_count to 0; keys in IDLE are ignored without key_err.
REQ-019 PIN digit: with digit_count<4, digit shifts into buffer, digit_count increments; at 4, digit rejected with key_err, buffer unchanged.
REQ-020 PIN enter: digit_count==4 drives pin_input from buffer, pulses pin_valid, returns IDLE; digit_count<4 pulses key_err, stays PIN.
REQ-021 AMT digit: accumulator becomes acc*10+digit, digit_count saturates at 7; if result >65535, digit rejected with key_err, accumulator unchanged.
REQ-022 AMT enter: digit_count>0 drives amount, pulses amount_valid, returns IDLE; digit_count==0 pulses key_err, stays AMT.
REQ-023 Backspace SHALL remove the last digit (PIN: shift right 4; AMT: acc/10), decrement digit_count; at digit_count 0 it pulses key_err.
REQ-024 Clear SHALL zero buffer/accumulator and digit_count, staying in the current entry state.
REQ-025 Cancel in PIN/AMT SHALL pulse cancel, zero buffer, return IDLE; pin_input/amount keep previous delivered values.
REQ-026 Codes E/F in PIN/AMT SHALL pulse key_err with no other effect.
REQ-027 pin_req/amount_req during an open entry SHALL be ignored.

Reset
REQ-028 rst SHALL force IDLE, pin_input=0, amount=0, digit_count=0, all pulses 0, inactivity counter 0; rst asserted mid-entry discards the entry without cancel or timeout pulse.

Configuration
REQ-029 With ATM_KEYPAD_TIMEOUT_EN defined, an inactivity counter SHALL reset on any key_valid and on entering PIN/AMT, and after TIMEOUT_CYCLES consecutive cycles without key_valid in PIN/AMT SHALL pulse timeout, clear buffer, return IDLE; key_valid on the expiry cycle takes precedence.
REQ-030 Without ATM_KEYPAD_TIMEOUT_EN, the timeout port SHALL remain present and tied 0, and no counter SHALL be built.

Structure
REQ-031 Package atm_pkg SHALL hold key-code constants, the entry-state enum, and the 65535 amount limit.
REQ-032 Sub-module atm_dec_accum SHALL implement the AMT accumulator (push digit, pop digit, clear, overflow flag).

Verification
REQ-033 pin_req; keys 1,2,3,4,C -> pin_input=16'h1234, pin_valid one cycle, entry_state 0.
REQ-034 amount_req; keys 1,0,0,C -> amount=16'h0064, amount_valid one cycle.
REQ-035 amount_req; keys 6,5,5,3,6 -> 6 rejected with key_err, amount stays 6553; keys 5,C -> amount=65535.
REQ-036 pin_req; keys 1,2,C -> key_err, stays PIN; B -> digit_count 1; 9,9,9,C -> pin_input=16'h1999.
REQ-037 pin_req; key 7, then D -> cancel pulse, pin_input unchanged; rst mid-AMT entry -> IDLE, all outputs 0.
REQ-038 With ATM_KEYPAD_TIMEOUT_EN, TIMEOUT_CYCLES=20: pin_req, no keys for 20 cycles -> timeout pulse, IDLE; key on cycle 19 restarts count.
